// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, two-word boot loader and IF/ID pipeline register.
// After reset the start PC is read from instruction memory words 0 (high half)
// and 1 (low half), then one instruction is fetched per cycle under control of
// the hazard unit (sequential / redirect / hold).
module fetch_pc_unit #(
    parameter int                  PC_W      = 32,
    parameter int                  INSTR_W   = 16,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pcSrc,
    input  logic               bubbleSignal,
    input  logic [PC_W-1:0]    jumpTarget,
    output logic [PC_W-1:0]    instrAddr,
    input  logic [INSTR_W-1:0] instrData,
    output logic [INSTR_W-1:0] ifidInstr,
    output logic [PC_W-1:0]    ifidPc,
    output logic               ifidValid,
    output logic               booting
);

    typedef enum logic [1:0] {
        BOOT_HI = 2'd0,
        BOOT_LO = 2'd1,
        RUN     = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ifid_t;

    state_t               state, state_nxt;
    logic [PC_W-1:0]      pc, pc_nxt;
    logic [INSTR_W-1:0]   boot_hi, boot_hi_nxt;
    ifid_t                ifid, ifid_nxt;
    logic                 hold, redirect;
    logic [2*INSTR_W-1:0] boot_word;

    // Hold (bubble or pcSrc=10) outranks redirect; 11 falls through to sequential.
    assign hold      = bubbleSignal | (pcSrc == 2'b10);
    assign redirect  = (pcSrc == 2'b01);
    assign boot_word = {boot_hi, instrData};

    // Next-state, next-PC, IF/ID update and fetch address.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        boot_hi_nxt = boot_hi;
        ifid_nxt    = ifid;
        instrAddr   = pc;
        case (state)
            BOOT_HI: begin
                instrAddr   = '0;
                boot_hi_nxt = instrData;
                state_nxt   = BOOT_LO;
            end
            BOOT_LO: begin
                instrAddr = PC_W'(1);
                pc_nxt    = boot_word[PC_W-1:0];
                state_nxt = RUN;
            end
            RUN: begin
                if (hold) begin
                    // freeze everything; same address is re-presented
                end else if (redirect) begin
                    // wrong-path instruction at pc is dropped; ifidPc kept
                    pc_nxt         = jumpTarget;
                    ifid_nxt.instr = NOP_INSTR;
                    ifid_nxt.valid = 1'b0;
                end else begin
                    ifid_nxt.instr = instrData;
                    ifid_nxt.pc    = pc + PC_W'(1);
                    ifid_nxt.valid = 1'b1;
                    pc_nxt         = pc + PC_W'(1);
                end
            end
            default: begin
                state_nxt = BOOT_HI;
            end
        endcase
    end

    // State, PC, boot latch and IF/ID registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BOOT_HI;
            pc      <= '0;
            boot_hi <= '0;
            ifid    <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            boot_hi <= boot_hi_nxt;
            ifid    <= ifid_nxt;
        end
    end

    assign ifidInstr = ifid.instr;
    assign ifidPc    = ifid.pc;
    assign ifidValid = ifid.valid;
    assign booting   = (state != RUN);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed boot/sequential/redirect/hold/wrap/reset
// steps followed by randomized hazard-unit traffic, checked against a
// transaction-level model of the fetch stage.
module tb_fetch_pc_unit;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pcSrc = 2'b00;
    logic        bubbleSignal = 1'b0;
    logic [31:0] jumpTarget = '0;
    logic [31:0] instrAddr;
    logic [15:0] instrData;
    logic [15:0] ifidInstr;
    logic [31:0] ifidPc;
    logic        ifidValid;
    logic        booting;

    fetch_pc_unit #(.PC_W(32), .INSTR_W(16), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pcSrc(pcSrc), .bubbleSignal(bubbleSignal),
        .jumpTarget(jumpTarget), .instrAddr(instrAddr), .instrData(instrData),
        .ifidInstr(ifidInstr), .ifidPc(ifidPc), .ifidValid(ifidValid),
        .booting(booting)
    );

    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    logic [15:0] w0, w1;
    logic [31:0] ov_a [8];
    logic [15:0] ov_d [8];
    int          n_ov = 0;
    int          mem_ver = 0;

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        if (a == 32'd0) return w0;
        if (a == 32'd1) return w1;
        for (int i = 0; i < n_ov; i++)
            if (ov_a[i] == a) return ov_d[i];
        return a[15:0] ^ a[31:16] ^ 16'hC3A5;
    endfunction

    task automatic set_mem(input logic [31:0] a, input logic [15:0] d);
        ov_a[n_ov] = a;
        ov_d[n_ov] = d;
        n_ov++;
        mem_ver++;
    endtask

    always @(instrAddr or mem_ver) instrData = mem_rd(instrAddr);

    // ---------------- reference model ----------------
    int          boot_left;     // words of boot sequence still to read
    logic [15:0] m_hi;
    logic [31:0] m_pc;
    logic [15:0] m_instr;
    logic [31:0] m_ifpc;
    logic        m_valid;

    int ncmp = 0;
    int nfail = 0;

    task automatic model_reset();
        boot_left = 2;
        m_hi = '0;
        m_pc = '0;
        m_instr = NOP;
        m_ifpc = '0;
        m_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ea;
        ea = (boot_left == 2) ? 32'd0 : (boot_left == 1) ? 32'd1 : m_pc;
        chk({tag, ".instrAddr"}, 64'(instrAddr), 64'(ea));
        chk({tag, ".ifidInstr"}, 64'(ifidInstr), 64'(m_instr));
        chk({tag, ".ifidPc"},    64'(ifidPc),    64'(m_ifpc));
        chk({tag, ".ifidValid"}, 64'(ifidValid), 64'(m_valid));
        chk({tag, ".booting"},   64'(booting),   64'(boot_left != 0));
    endtask

    // One clock: drive hazard inputs, advance model, compare after the edge.
    task automatic step(input string tag, input logic [1:0] src, input logic bub,
                        input logic [31:0] tgt);
        pcSrc = src;
        bubbleSignal = bub;
        jumpTarget = tgt;
        @(posedge clk);
        if (boot_left == 2) begin
            m_hi = mem_rd(32'd0);
            boot_left = 1;
        end else if (boot_left == 1) begin
            m_pc = {m_hi, mem_rd(32'd1)};
            boot_left = 0;
        end else if (bub || src == 2'b10) begin
            // stalled
        end else if (src == 2'b01) begin
            m_pc = tgt;
            m_instr = NOP;
            m_valid = 1'b0;
        end else begin
            m_instr = mem_rd(m_pc);
            m_ifpc = m_pc + 32'd1;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd1;
        end
        #1;
        check_all(tag);
    endtask

    // Reset pulse between edges; outputs must settle without a clock.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        w0 = 16'h0000;
        w1 = 16'h0020;
        mem_ver++;
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1. boot; redirect requests during boot are ignored
        step("boot0", 2'b01, 1'b0, 32'h999);
        step("boot1", 2'b01, 1'b1, 32'h999);
        chk("boot.pc", 64'(instrAddr), 64'h20);

        // 2. sequential
        set_mem(32'h20, 16'h1111);
        set_mem(32'h21, 16'h2222);
        set_mem(32'h22, 16'h3333);
        set_mem(32'h100, 16'hABCD);
        step("seq0", 2'b00, 1'b0, '0);
        chk("seq0.const", 64'(ifidInstr), 64'h1111);
        step("seq1", 2'b00, 1'b0, '0);

        // 3. redirect at pc=0x22
        step("redir", 2'b01, 1'b0, 32'h100);
        chk("redir.pc", 64'(instrAddr), 64'h100);
        step("redir.tgt", 2'b00, 1'b0, '0);
        chk("redir.tgt.const", 64'(ifidInstr), 64'hABCD);

        // 4. hold at pc=0x40
        set_mem(32'h40, 16'h4040);
        step("to40", 2'b01, 1'b0, 32'h40);
        step("hold0", 2'b10, 1'b1, '0);
        step("hold1", 2'b10, 1'b1, '0);
        step("hold_vs_redir", 2'b01, 1'b1, 32'h777);
        chk("hold_vs_redir.pc", 64'(instrAddr), 64'h40);
        step("hold_pcsrc_only", 2'b10, 1'b0, '0);
        step("release", 2'b00, 1'b0, '0);
        chk("release.const", 64'(ifidInstr), 64'h4040);

        // 5. wrap at all-ones, and pcSrc=11 acts as sequential
        w0 = 16'hFFFF;
        w1 = 16'hFFFF;
        mem_ver++;
        reset_pulse("rst_wrap");
        step("wboot0", 2'b00, 1'b0, '0);
        step("wboot1", 2'b00, 1'b0, '0);
        step("wrap", 2'b00, 1'b0, '0);
        chk("wrap.ifidPc", 64'(ifidPc), 64'h0);
        step("src11", 2'b11, 1'b0, '0);

        // 6. mid-run reset re-reads boot words
        w0 = 16'h0001;
        w1 = 16'h0004;
        mem_ver++;
        reset_pulse("rst_mid");
        step("rboot0", 2'b00, 1'b0, '0);
        step("rboot1", 2'b00, 1'b0, '0);
        chk("rboot.pc", 64'(instrAddr), 64'h10004);

        // randomized traffic with occasional resets (also mid-boot)
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  s;
            logic        b;
            logic [31:0] t;
            s = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 4) == 0);
            t = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            if ($urandom_range(0, 49) == 0) begin
                w0 = 16'($urandom);
                w1 = 16'($urandom);
                mem_ver++;
                reset_pulse("rnd_rst");
            end else begin
                step("rnd", s, b, t);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly downstream of the hazard detection unit.
- Owns the PC register and the IF/ID pipeline register.
- Consumes `pcSrc` and `bubbleSignal` to advance, redirect or hold fetch.
- After reset, runs a two-word boot sequence that loads the start PC from instruction memory words 0 and 1, then fetches one 16-bit instruction per cycle into IF/ID.

Parameters:
- PC_W, 32: PC and address width; 17..32.
- INSTR_W, 16: instruction word width; fixed at 16.
- NOP_INSTR, 16'h0000: encoding inserted into IF/ID on flush and reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pcSrc  input  2  from hazard unit: 00 sequential, 01 jump/branch taken, 10 hold (load-use bubble), 11 reserved.
- bubbleSignal  input  1  from hazard unit; 1 = freeze PC and IF/ID.
- jumpTarget  input  PC_W  redirect address; valid when pcSrc==01.
- instrAddr  output  PC_W  instruction memory address; combinational from state/PC.
- instrData  input  INSTR_W  instruction memory read data; asynchronous read, valid in the same cycle as instrAddr.
- ifidInstr  output  INSTR_W  registered instruction to decode.
- ifidPc  output  PC_W  registered PC+1 of ifidInstr, used as return address.
- ifidValid  output  1  registered; 1 = ifidInstr is a real fetched instruction.
- booting  output  1  1 while the boot FSM is not in RUN.

Behaviour:
- Reset (async, takes effect immediately, any state):
  - state=BOOT_HI, pc=0, bootHi=0
  - ifidInstr=NOP_INSTR, ifidPc=0, ifidValid=0
- FSM states: BOOT_HI, BOOT_LO, RUN.
- BOOT_HI:
  - instrAddr=0.
  - Edge: bootHi<=instrData; state<=BOOT_LO.
- BOOT_LO:
  - instrAddr=1.
  - Edge: pc<={bootHi,instrData}[PC_W-1:0]; state<=RUN.
- During BOOT_*:
  - pcSrc, bubbleSignal and jumpTarget are ignored.
  - ifidValid stays 0; ifidInstr stays NOP_INSTR; booting=1.
- RUN: instrAddr=pc; booting=0. Per edge, priority highest first:
  1. Hold, when bubbleSignal==1 OR pcSrc==10: pc, ifidInstr, ifidPc and ifidValid all unchanged. The same address is re-presented next cycle.
  2. Redirect, when pcSrc==01: pc<=jumpTarget; ifidInstr<=NOP_INSTR; ifidValid<=0; ifidPc unchanged. The wrong-path instruction at the current pc is discarded.
  3. Sequential, when pcSrc==00 or 11: ifidInstr<=instrData; ifidPc<=pc+1; ifidValid<=1; pc<=pc+1.
- Arithmetic: pc+1 is modulo 2^PC_W, so the all-ones value wraps to 0 with no flag.
- Latency: an instruction at address A appears on ifidInstr one edge after pc==A in RUN (absent hold or redirect).
- Redirect penalty: one NOP slot in IF/ID; the target instruction is valid in IF/ID two edges after redirect.
- Hold and redirect asserted in the same cycle: hold wins. Redirect is expected to be re-asserted by the hazard unit once the bubble clears; this block does not remember it.
- No X propagation: a bubbleSignal or pcSrc value of X in RUN is a bench error. Outputs must not depend on X-optimism.
- Reset asserted mid-run or mid-boot:
  - Outputs reach their reset values without waiting for a clock edge.
  - On deassertion, boot restarts from BOOT_HI.

Test Plan:
1. Boot: M[0]=16'h0000, M[1]=16'h0020; release rst → instrAddr=0 then 1. After 2 edges pc=32'h20, booting=0. ifidValid=0 throughout; pcSrc=01 applied during boot has no effect.
2. Sequential: from pc=0x20, M[0x20..0x22]=16'h1111/2222/3333, pcSrc=00 → ifidInstr 1111, 2222, 3333 on consecutive edges. ifidPc 0x21, 0x22, 0x23; ifidValid=1.
3. Redirect: at pc=0x22 set pcSrc=01, jumpTarget=0x100 for one cycle, M[0x100]=16'hABCD → next edge ifidInstr=NOP_INSTR, ifidValid=0, pc=0x100. Following edge ifidInstr=ABCD, ifidPc=0x101.
4. Hold: bubbleSignal=1, pcSrc=10 for 2 cycles at pc=0x40 → pc, ifidInstr and ifidPc frozen for 2 edges. Release → the instruction at 0x40 enters IF/ID. Hold plus pcSrc=01 simultaneously → hold wins, pc stays 0x40.
5. Wrap: boot to pc=32'hFFFFFFFF, pcSrc=00 → ifidPc=0, pc=0. pcSrc=11 behaves identically to 00.
6. Mid-run reset: pulse rst between clock edges in RUN → ifidValid=0, ifidInstr=NOP_INSTR and booting=1 immediately. Boot re-reads words 0 and 1.
